// File: rtl/fifo_pkg.sv
// -----------------------------------------------------------------------------
// fifo_pkg
// Shared sizing defaults and occupancy-FSM state encodings for the transaction
// layer FIFO controller (fifo_ctrl) and its pointer sub-module (fifo_ptr).
//   DEPTH  : entries in the 10-bit x 8-deep storage array
//   PTR_W  : width of the array address ports
//   CNT_W  : occupancy counter width, holds 0..DEPTH inclusive
// -----------------------------------------------------------------------------
package fifo_pkg;
   localparam int DEPTH = 8;
   localparam int PTR_W = 4;
   localparam int CNT_W = 4;

   localparam logic [1:0] ST_EMPTY   = 2'd0;
   localparam logic [1:0] ST_PARTIAL = 2'd1;
   localparam logic [1:0] ST_FULL    = 2'd2;
endpackage

// File: rtl/fifo_ptr.sv
// -----------------------------------------------------------------------------
// fifo_ptr
// Wrapping address register: advances by one when inc is high and wraps from
// DEPTH-1 back to 0. Bits above the used address range therefore stay 0.
// Ports:
//   clk      in   1      rising-edge clock
//   reset_L  in   1      asynchronous active-low reset (pointer -> 0)
//   inc      in   1      advance enable
//   ptr      out  PTR_W  current address
// -----------------------------------------------------------------------------
module fifo_ptr #(
   parameter int DEPTH = fifo_pkg::DEPTH,
   parameter int PTR_W = fifo_pkg::PTR_W
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             inc,
   output logic [PTR_W-1:0] ptr
);
   import fifo_pkg::*;

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
      end
   end
endmodule

// File: rtl/fifo_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_ctrl
// Pointer/flag controller for the 10-bit x 8-deep FIFO storage array.
// Qualifies push/pop, drives the array strobes and addresses, tracks occupancy
// and decodes full/empty/almost flags plus a read-data-valid strobe aligned
// with the array's one-cycle registered read.
// Optional build macro: FIFO_ERR_EN adds the sticky fifo_error output
// (overflow / underflow); without it illegal requests are silently dropped.
// Ports:
//   clk, reset_L          clock, asynchronous active-low reset
//   push, pop             producer / consumer requests
//   af_thr, ae_thr        almost-full / almost-empty thresholds (CNT_W)
//   wr_en, rd_en          combinational accepted-push / accepted-pop strobes
//   wr_ptr, rd_ptr        registered array addresses (PTR_W)
//   rd_valid              array data_out valid (rd_en delayed one cycle)
//   count                 registered occupancy (CNT_W)
//   full, empty           registered occupancy flags from the FSM state
//   almost_full           registered count >= af_thr
//   almost_empty          registered count <= ae_thr
//   fifo_error            sticky error flag (FIFO_ERR_EN builds only)
// -----------------------------------------------------------------------------
module fifo_ctrl #(
   parameter int DEPTH = fifo_pkg::DEPTH,
   parameter int PTR_W = fifo_pkg::PTR_W,
   parameter int CNT_W = fifo_pkg::CNT_W
) (
   input  logic             clk,
   input  logic             reset_L,
   input  logic             push,
   input  logic             pop,
   input  logic [CNT_W-1:0] af_thr,
   input  logic [CNT_W-1:0] ae_thr,
   output logic             wr_en,
   output logic             rd_en,
   output logic [PTR_W-1:0] wr_ptr,
   output logic [PTR_W-1:0] rd_ptr,
   output logic             rd_valid,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty,
   output logic             almost_full,
   output logic             almost_empty
`ifdef FIFO_ERR_EN
  ,output logic             fifo_error
`endif
);
   import fifo_pkg::*;

   logic             pop_ok;
   logic             push_ok;
   logic [1:0]       state_p0;
   logic [1:0]       state_nxt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             rd_vld_p1;

   // A push while full only goes through alongside a pop: the array reads the
   // old word at that address on the same edge, so nothing is overwritten early.
   // No bypass: while empty a simultaneous pop is refused.
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign wr_en   = push_ok;
   assign rd_en   = pop_ok;

   fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_wr_ptr (
      .clk     (clk),
      .reset_L (reset_L),
      .inc     (push_ok),
      .ptr     (wr_ptr)
   );

   fifo_ptr #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_rd_ptr (
      .clk     (clk),
      .reset_L (reset_L),
      .inc     (pop_ok),
      .ptr     (rd_ptr)
   );

   always_comb begin
      cnt_nxt = count;
      case ({push_ok, pop_ok})
         2'b10:   cnt_nxt = count + CNT_W'(1);
         2'b01:   cnt_nxt = count - CNT_W'(1);
         default: cnt_nxt = count;
      endcase
   end

   always_comb begin
      state_nxt = state_p0;
      case (state_p0)
         ST_EMPTY:   if (push_ok) state_nxt = ST_PARTIAL;
         ST_PARTIAL: begin
            if (pop_ok && !push_ok && count == CNT_W'(1))
               state_nxt = ST_EMPTY;
            else if (push_ok && !pop_ok && count == CNT_W'(DEPTH - 1))
               state_nxt = ST_FULL;
         end
         ST_FULL:    if (pop_ok && !push_ok) state_nxt = ST_PARTIAL;
         default:    state_nxt = ST_EMPTY;
      endcase
   end

   // ---- p0 -> p1 : occupancy state, count, almost flags, read-valid ----
   // Threshold corner cases fall out of the compares: af_thr==0 always
   // satisfies >=, and ae_thr>=DEPTH always satisfies <= since count<=DEPTH.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         state_p0     <= ST_EMPTY;
         count        <= '0;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         rd_vld_p1    <= 1'b0;
      end else begin
         state_p0     <= state_nxt;
         count        <= cnt_nxt;
         almost_full  <= (cnt_nxt >= af_thr);
         almost_empty <= (cnt_nxt <= ae_thr);
         rd_vld_p1    <= pop_ok;
      end
   end

   assign empty    = (state_p0 == ST_EMPTY);
   assign full     = (state_p0 == ST_FULL);
   assign rd_valid = rd_vld_p1;

`ifdef FIFO_ERR_EN
   // Sticky until reset; the rejected request itself is already gated above.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         fifo_error <= 1'b0;
      end else if ((push && full && !pop_ok) || (pop && empty)) begin
         fifo_error <= 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_fifo_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_ctrl
// Table-driven bench for fifo_ctrl with a small storage array model so the
// popped data order can be observed. Build with +define+FIFO_ERR_EN to also
// cover the sticky error flag.
// -----------------------------------------------------------------------------
module tb_fifo_ctrl;
   logic       clk = 1'b0;
   logic       reset_L = 1'b1;
   logic       push = 1'b0;
   logic       pop = 1'b0;
   logic [3:0] af_thr = 4'd6;
   logic [3:0] ae_thr = 4'd2;
   logic       wr_en, rd_en, rd_valid, full, empty, almost_full, almost_empty;
   logic [3:0] wr_ptr, rd_ptr, count;
   logic [9:0] din = '0;
   logic [9:0] dout;
   logic [9:0] mem [8];
`ifdef FIFO_ERR_EN
   logic       fifo_error;
`endif

   int n_pass = 0;
   int n_total = 0;

   fifo_ctrl dut (
      .clk          (clk),
      .reset_L      (reset_L),
      .push         (push),
      .pop          (pop),
      .af_thr       (af_thr),
      .ae_thr       (ae_thr),
      .wr_en        (wr_en),
      .rd_en        (rd_en),
      .wr_ptr       (wr_ptr),
      .rd_ptr       (rd_ptr),
      .rd_valid     (rd_valid),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty)
`ifdef FIFO_ERR_EN
     ,.fifo_error   (fifo_error)
`endif
   );

   always #5 clk = ~clk;

   // Storage array driven by the controller strobes, registered read.
   always @(posedge clk) begin
      if (wr_en) mem[wr_ptr[2:0]] <= din;
      if (rd_en) dout <= mem[rd_ptr[2:0]];
   end

   typedef struct {
      logic       push, pop;
      logic [9:0] din;
      logic       wr, rd;
      logic [3:0] wp, rp, cnt;
      logic       f, e, af, ae, rv;
      logic [9:0] dout;
      logic       err;
   } vec_t;

   vec_t vt[22];

   function automatic vec_t mk(logic p, logic po, logic [9:0] d, logic w, logic r,
                               logic [3:0] wp, logic [3:0] rp, logic [3:0] c,
                               logic f, logic e, logic af, logic ae, logic rv,
                               logic [9:0] dq, logic er);
      vec_t v;
      v.push = p; v.pop = po; v.din = d; v.wr = w; v.rd = r;
      v.wp = wp; v.rp = rp; v.cnt = c; v.f = f; v.e = e;
      v.af = af; v.ae = ae; v.rv = rv; v.dout = dq; v.err = er;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, " wr_ptr"}, 32'(wr_ptr), 0);
      chk({tag, " rd_ptr"}, 32'(rd_ptr), 0);
      chk({tag, " count"}, 32'(count), 0);
      chk({tag, " rd_valid"}, 32'(rd_valid), 0);
      chk({tag, " empty"}, 32'(empty), 1);
      chk({tag, " full"}, 32'(full), 0);
      chk({tag, " almost_empty"}, 32'(almost_empty), 1);
      chk({tag, " almost_full"}, 32'(almost_full), 0);
`ifdef FIFO_ERR_EN
      chk({tag, " fifo_error"}, 32'(fifo_error), 0);
`endif
   endtask

   initial begin
      //         push pop din     wr rd wp rp cnt f e af ae rv dout  err
      vt[0]  = mk(1, 0, 10'h001, 1, 0, 1, 0, 1, 0, 0, 0, 1, 0, 10'h000, 0);
      vt[1]  = mk(1, 0, 10'h002, 1, 0, 2, 0, 2, 0, 0, 0, 1, 0, 10'h000, 0);
      vt[2]  = mk(1, 0, 10'h003, 1, 0, 3, 0, 3, 0, 0, 0, 0, 0, 10'h000, 0);
      vt[3]  = mk(1, 0, 10'h004, 1, 0, 4, 0, 4, 0, 0, 0, 0, 0, 10'h000, 0);
      vt[4]  = mk(1, 0, 10'h005, 1, 0, 5, 0, 5, 0, 0, 0, 0, 0, 10'h000, 0);
      vt[5]  = mk(1, 0, 10'h006, 1, 0, 6, 0, 6, 0, 0, 1, 0, 0, 10'h000, 0);
      vt[6]  = mk(1, 0, 10'h007, 1, 0, 7, 0, 7, 0, 0, 1, 0, 0, 10'h000, 0);
      vt[7]  = mk(1, 0, 10'h008, 1, 0, 0, 0, 8, 1, 0, 1, 0, 0, 10'h000, 0);
      vt[8]  = mk(1, 0, 10'h009, 0, 0, 0, 0, 8, 1, 0, 1, 0, 0, 10'h000, 1);
      vt[9]  = mk(1, 1, 10'h009, 1, 1, 1, 1, 8, 1, 0, 1, 0, 1, 10'h001, 1);
      vt[10] = mk(0, 0, 10'h000, 0, 0, 1, 1, 8, 1, 0, 1, 0, 0, 10'h000, 1);
      vt[11] = mk(0, 1, 10'h000, 0, 1, 1, 2, 7, 0, 0, 1, 0, 1, 10'h002, 1);
      vt[12] = mk(0, 1, 10'h000, 0, 1, 1, 3, 6, 0, 0, 1, 0, 1, 10'h003, 1);
      vt[13] = mk(0, 1, 10'h000, 0, 1, 1, 4, 5, 0, 0, 0, 0, 1, 10'h004, 1);
      vt[14] = mk(0, 1, 10'h000, 0, 1, 1, 5, 4, 0, 0, 0, 0, 1, 10'h005, 1);
      vt[15] = mk(0, 1, 10'h000, 0, 1, 1, 6, 3, 0, 0, 0, 0, 1, 10'h006, 1);
      vt[16] = mk(0, 1, 10'h000, 0, 1, 1, 7, 2, 0, 0, 0, 1, 1, 10'h007, 1);
      vt[17] = mk(0, 1, 10'h000, 0, 1, 1, 0, 1, 0, 0, 0, 1, 1, 10'h008, 1);
      vt[18] = mk(0, 1, 10'h000, 0, 1, 1, 1, 0, 0, 1, 0, 1, 1, 10'h009, 1);
      vt[19] = mk(0, 1, 10'h000, 0, 0, 1, 1, 0, 0, 1, 0, 1, 0, 10'h000, 1);
      vt[20] = mk(1, 1, 10'h0AA, 1, 0, 2, 1, 1, 0, 0, 0, 1, 0, 10'h000, 1);
      vt[21] = mk(0, 1, 10'h000, 0, 1, 2, 2, 0, 0, 1, 0, 1, 1, 10'h0AA, 1);

      // Power-on reset, checked before the first clock edge.
      #1 reset_L = 1'b0;
      #1 check_reset("por");
      @(negedge clk);
      reset_L = 1'b1;

      for (int i = 0; i < 22; i++) begin
         @(negedge clk);
         push = vt[i].push; pop = vt[i].pop; din = vt[i].din;
         #1;
         chk($sformatf("v%0d wr_en", i), 32'(wr_en), 32'(vt[i].wr));
         chk($sformatf("v%0d rd_en", i), 32'(rd_en), 32'(vt[i].rd));
         @(posedge clk);
         #1;
         chk($sformatf("v%0d wr_ptr", i), 32'(wr_ptr), 32'(vt[i].wp));
         chk($sformatf("v%0d rd_ptr", i), 32'(rd_ptr), 32'(vt[i].rp));
         chk($sformatf("v%0d count", i), 32'(count), 32'(vt[i].cnt));
         chk($sformatf("v%0d full", i), 32'(full), 32'(vt[i].f));
         chk($sformatf("v%0d empty", i), 32'(empty), 32'(vt[i].e));
         chk($sformatf("v%0d almost_full", i), 32'(almost_full), 32'(vt[i].af));
         chk($sformatf("v%0d almost_empty", i), 32'(almost_empty), 32'(vt[i].ae));
         chk($sformatf("v%0d rd_valid", i), 32'(rd_valid), 32'(vt[i].rv));
         if (vt[i].rv) chk($sformatf("v%0d dout", i), 32'(dout), 32'(vt[i].dout));
`ifdef FIFO_ERR_EN
         chk($sformatf("v%0d fifo_error", i), 32'(fifo_error), 32'(vt[i].err));
`endif
      end

      // Threshold corners: af_thr=0 forces almost_full, ae_thr>=DEPTH forces almost_empty.
      @(negedge clk);
      push = 1'b0; pop = 1'b0; af_thr = 4'd0; ae_thr = 4'd8;
      @(posedge clk); #1;
      chk("thr0 almost_full@0", 32'(almost_full), 1);
      chk("thr8 almost_empty@0", 32'(almost_empty), 1);
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         push = 1'b1; din = 10'(k + 16);
      end
      @(posedge clk); #1;
      chk("fill count", 32'(count), 8);
      chk("fill full", 32'(full), 1);
      chk("fill wr_ptr wrap", 32'(wr_ptr), 2);
      chk("thr8 almost_empty@8", 32'(almost_empty), 1);
      chk("thr0 almost_full@8", 32'(almost_full), 1);

      // Asynchronous reset between edges while a pop is in flight.
      @(negedge clk);
      push = 1'b1; pop = 1'b1;
      @(posedge clk); #1;
      chk("pre-reset rd_valid", 32'(rd_valid), 1);
      #2 reset_L = 1'b0;
      #1 check_reset("async");
      @(negedge clk);
      reset_L = 1'b1; push = 1'b1; pop = 1'b1; din = 10'h155;
      #1;
      chk("post-reset wr_en", 32'(wr_en), 1);
      chk("post-reset rd_en", 32'(rd_en), 0);
      @(posedge clk); #1;
      chk("post-reset count", 32'(count), 1);
      chk("post-reset wr_ptr", 32'(wr_ptr), 1);
      chk("post-reset empty", 32'(empty), 0);
`ifdef FIFO_ERR_EN
      chk("post-reset fifo_error", 32'(fifo_error), 0);
`endif
      @(negedge clk);
      push = 1'b0; pop = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
